// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared encodings and grant helper for the unified memory arbiter
package unified_mem_arbiter_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_BUSY_IF = 3'd1;
  localparam logic [2:0] ST_BUSY_DM = 3'd2;
  localparam logic [2:0] ST_DONE_IF = 3'd3;
  localparam logic [2:0] ST_DONE_DM = 3'd4;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;

  // With FAIR set, a tie goes to whichever port did not win last time.
  function automatic logic pick_dm(input logic fair, input logic fetch_req,
                                   input logic data_req, input logic last);
    if (!data_req)
      pick_dm = 1'b0;
    else if (!fetch_req)
      pick_dm = 1'b1;
    else if (!fair)
      pick_dm = 1'b1;
    else
      pick_dm = (last == GRANT_IF);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - busy-cycle counter that flags when an access has waited too long
module arb_wait_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= 8'd0;
    else if (clear)
      count <= 8'd0;
    else if (enable)
      count <= count + 8'd1;
  end

  // Fires during the busy cycle that would bring the count up to TIMEOUT.
  assign expired = enable && (({1'b0, count} + 9'd1) == 9'(TIMEOUT));

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - arbitrates fetch and load/store ports onto one single-ported memory
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter logic        FAIR     = 1'b0,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_WORD = ERR_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        pipe_hold,
  output logic        bus_err
);

  logic [2:0] state;
  logic       last_grant;
  logic       dm_req;
  logic       dm_win;
  logic       busy;
  logic       wc_expired;

  assign dm_req    = dm_rd | dm_wr;
  assign dm_win    = pick_dm(FAIR, if_req, dm_req, last_grant);
  assign busy      = (state == ST_BUSY_IF) || (state == ST_BUSY_DM);
  assign if_ready  = (state == ST_DONE_IF);
  assign dm_ready  = (state == ST_DONE_DM);
  assign pipe_hold = (if_req & ~if_ready) | (dm_req & ~dm_ready);

  // Holding the counter clear in IDLE gives a fresh count on every entry to BUSY.
  arb_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == ST_IDLE),
    .enable  (busy),
    .expired (wc_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_IF;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      if_rdata   <= 32'd0;
      dm_rdata   <= 32'd0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dm_win) begin
            state      <= ST_BUSY_DM;
            last_grant <= GRANT_DM;
            mem_req    <= 1'b1;
            mem_we     <= dm_wr;
            mem_addr   <= dm_addr;
            mem_wdata  <= dm_wdata;
            if (dm_rd && dm_wr)
              bus_err <= 1'b1;
          end else if (if_req) begin
            state      <= ST_BUSY_IF;
            last_grant <= GRANT_IF;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= 32'd0;
          end
        end
        ST_BUSY_IF: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            state    <= ST_DONE_IF;
          end else if (wc_expired) begin
            mem_req  <= 1'b0;
            if_rdata <= ERR_WORD;
            bus_err  <= 1'b1;
            state    <= ST_DONE_IF;
          end
        end
        ST_BUSY_DM: begin
          // Stores leave dm_rdata untouched on both completion paths.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we)
              dm_rdata <= mem_rdata;
            state <= ST_DONE_DM;
          end else if (wc_expired) begin
            mem_req <= 1'b0;
            if (!mem_we)
              dm_rdata <= ERR_WORD;
            bus_err <= 1'b1;
            state   <= ST_DONE_DM;
          end
        end
        ST_DONE_IF: state <= ST_IDLE;
        ST_DONE_DM: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule
